// File: rtl/decoder8_seq.sv
// decoder8_seq: registered 3-to-8 one-hot decoder (code k drives y[7-k]) behind a
// valid/ready handshake, holding each output DWELL cycles then GAP zero cycles.
// Optional sweep mode (codes 0..7 back to back) is enabled by defining DEC8_SWEEP_EN.
module decoder8_seq #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       en_in,
`ifdef DEC8_SWEEP_EN
    input  logic       sweep_start,
`endif
    output logic       rdy_out,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A zero dwell behaves like a single-cycle dwell.
    localparam int         DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
    localparam logic [7:0] DWELL_LD  = 8'(DWELL_EFF - 1);
    localparam bit         GAP_ON    = (GAP > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] GAP_LD    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    function automatic logic [7:0] onehot(input logic [2:0] k);
        onehot = 8'h80 >> k;
    endfunction

    state_t     state_r;
    state_t     state_nx_s;
    logic [2:0] code_r;
    logic [2:0] code_nx_s;
    logic [7:0] dcnt_r;
    logic [7:0] dcnt_nx_s;
    logic [3:0] gcnt_r;
    logic [3:0] gcnt_nx_s;
    logic [7:0] y_r;
    logic [7:0] y_nx_s;
    logic       busy_r;
    logic       busy_nx_s;
    logic       done_r;
    logic       done_nx_s;
    logic       start_sweep_s;
    logic       more_steps_s;
    logic       sweep_nx_s;

`ifdef DEC8_SWEEP_EN
    logic sweep_r;

    assign start_sweep_s = sweep_start;
    assign more_steps_s  = sweep_r & (code_r != 3'd7);
    // The flag is taken on entry from IDLE and dropped whenever the sequencer returns to IDLE.
    assign sweep_nx_s    = (state_r == ST_IDLE) ? sweep_start
                                                : (sweep_r & (state_nx_s != ST_IDLE));

    // Sweep-mode flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_r <= 1'b0;
        end else begin
            sweep_r <= sweep_nx_s;
        end
    end
`else
    assign start_sweep_s = 1'b0;
    assign more_steps_s  = 1'b0;
    assign sweep_nx_s    = 1'b0;
`endif

    // Next-state, captured code and dwell/gap counters.
    always_comb begin
        state_nx_s = state_r;
        code_nx_s  = code_r;
        dcnt_nx_s  = dcnt_r;
        gcnt_nx_s  = gcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_sweep_s) begin
                    state_nx_s = ST_DRIVE;
                    code_nx_s  = 3'd0;
                    dcnt_nx_s  = DWELL_LD;
                end else if (en_in) begin
                    state_nx_s = ST_DRIVE;
                    code_nx_s  = code_in;
                    dcnt_nx_s  = DWELL_LD;
                end else begin
                    dcnt_nx_s  = 8'd0;
                    gcnt_nx_s  = 4'd0;
                end
            end
            ST_DRIVE: begin
                if (dcnt_r != 8'd0) begin
                    dcnt_nx_s  = dcnt_r - 8'd1;
                end else if (GAP_ON) begin
                    state_nx_s = ST_GAP;
                    gcnt_nx_s  = GAP_LD;
                end else if (more_steps_s) begin
                    // Sweep with no guard gap: next code follows immediately.
                    state_nx_s = ST_DRIVE;
                    code_nx_s  = code_r + 3'd1;
                    dcnt_nx_s  = DWELL_LD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gcnt_r != 4'd0) begin
                    gcnt_nx_s  = gcnt_r - 4'd1;
                end else if (more_steps_s) begin
                    state_nx_s = ST_DRIVE;
                    code_nx_s  = code_r + 3'd1;
                    dcnt_nx_s  = DWELL_LD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                dcnt_nx_s  = 8'd0;
                gcnt_nx_s  = 4'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they register in step.
    always_comb begin
        y_nx_s    = 8'h00;
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        if (state_nx_s == ST_DRIVE) begin
            y_nx_s    = onehot(code_nx_s);
            busy_nx_s = 1'b1;
            // Within a sweep only the final code reports completion.
            done_nx_s = (dcnt_nx_s == 8'd0) & (~sweep_nx_s | (code_nx_s == 3'd7));
        end else if (state_nx_s == ST_GAP) begin
            busy_nx_s = 1'b1;
        end else begin
            y_nx_s    = 8'h00;
            busy_nx_s = 1'b0;
            done_nx_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            code_r  <= 3'd0;
            dcnt_r  <= 8'd0;
            gcnt_r  <= 4'd0;
            y_r     <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            code_r  <= code_nx_s;
            dcnt_r  <= dcnt_nx_s;
            gcnt_r  <= gcnt_nx_s;
            y_r     <= y_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    assign rdy_out = (state_r == ST_IDLE) & ~rst;
    assign y       = y_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_decoder8_seq.sv
// Self-checking bench for decoder8_seq: default instance (DWELL=4, GAP=1) checked through
// an output-burst scoreboard, plus a DWELL=1/GAP=0 instance for minimum timing.
module tb_decoder8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_in;
    logic [2:0] code_in;
    logic       rdy_out;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       en_b;
    logic [2:0] code_b;
    logic       rdy_b;
    logic [7:0] y_b;
    logic       busy_b;
    logic       done_b;
`ifdef DEC8_SWEEP_EN
    logic       sweep_start;
    logic       sweep_b;
`endif

    always #5 clk = ~clk;

    decoder8_seq #(.DWELL(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .en_in(en_in),
`ifdef DEC8_SWEEP_EN
        .sweep_start(sweep_start),
`endif
        .rdy_out(rdy_out), .y(y), .busy(busy), .done(done)
    );

    decoder8_seq #(.DWELL(1), .GAP(0)) dut_min (
        .clk(clk), .rst(rst), .code_in(code_b), .en_in(en_b),
`ifdef DEC8_SWEEP_EN
        .sweep_start(sweep_b),
`endif
        .rdy_out(rdy_b), .y(y_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic [7:0] yv;
        int         len;
        logic       dn;
    } exp_t;

    exp_t       q[$];
    logic [7:0] qb[$];
    exp_t       cur;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_y = 8'h00;
    int         run_len = 0;
    logic       last_done = 1'b0;
    logic       early_done = 1'b0;

    function automatic logic [7:0] onehot(input logic [2:0] k);
        return 8'h80 >> k;
    endfunction

    task automatic push_exp(input logic [7:0] yv, input int len, input logic dn);
        exp_t e;
        e.yv = yv;
        e.len = len;
        e.dn = dn;
        q.push_back(e);
    endtask

    task automatic close_burst();
        checks++;
        if (run_len != cur.len) begin
            errors++;
            $display("FAIL burst_len: y=%h held %0d cycles, expected %0d", cur.yv, run_len, cur.len);
        end
        checks++;
        if (last_done !== cur.dn) begin
            errors++;
            $display("FAIL burst_done: y=%h done in last cycle=%b, expected %b", cur.yv, last_done, cur.dn);
        end
        checks++;
        if (early_done) begin
            errors++;
            $display("FAIL done_early: y=%h done=1 before last cycle, expected 0", cur.yv);
        end
    endtask

    // Scoreboard monitor for the default instance, called once per negedge.
    task automatic mon();
        if (y !== 8'h00 && y !== prev_y) begin
            if (prev_y !== 8'h00) close_burst();
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_y: y=%h with empty scoreboard, expected 00", y);
                cur.yv = y;
                cur.len = 4;
                cur.dn = 1'b1;
            end else begin
                cur = q.pop_front();
                if (y !== cur.yv) begin
                    errors++;
                    $display("FAIL y_value: y=%h, expected %h", y, cur.yv);
                end
            end
            run_len = 1;
            early_done = 1'b0;
            last_done = done;
        end else if (y !== 8'h00) begin
            if (last_done) early_done = 1'b1;
            run_len++;
            last_done = done;
        end else begin
            if (prev_y !== 8'h00) close_burst();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_idle: done=%b while y=00, expected 0", done);
            end
        end
        prev_y = y;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    // One transfer on the default instance; checks the 6-cycle accept period.
    task automatic send(input logic [2:0] c, input logic [2:0] nc, input logic hold);
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL accept_rdy: rdy_out=%b before code %0d, expected 1", rdy_out, c);
        end
        en_in = 1'b1;
        code_in = c;
        push_exp(onehot(c), 4, 1'b1);
        cyc();
        en_in = hold;
        code_in = nc;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            checks++;
            if (rdy_out !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_phase: cycle %0d rdy=%b busy=%b, expected 0 1", i, rdy_out, busy);
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b after gap, expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_in = 1'b1;
        code_in = 3'd5;
        en_b = 1'b0;
        code_b = 3'd0;
`ifdef DEC8_SWEEP_EN
        sweep_start = 1'b0;
        sweep_b = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rdy_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: y=%h busy=%b done=%b rdy=%b, expected 00 0 0 0",
                         y, busy, done, rdy_out);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: rdy_out=%b after reset release, expected 1", rdy_out);
        end
        send(3'd5, 3'd0, 1'b0);
    endtask

    task automatic test_single();
        send(3'd0, 3'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            send(3'(k), 3'(k + 1), (k < 7) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_hold();
        send(3'd2, 3'd7, 1'b1);
        send(3'd7, 3'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_rdy: rdy_out=%b before code 6, expected 1", rdy_out);
        end
        en_in = 1'b1;
        code_in = 3'd6;
        push_exp(8'h02, 2, 1'b0);
        cyc();
        en_in = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rdy_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: y=%h busy=%b done=%b rdy=%b, expected 00 0 0 0",
                     y, busy, done, rdy_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: rdy_out=%b after reset release, expected 1", rdy_out);
        end
    endtask

    task automatic test_min_timing();
        logic [7:0] e;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rdy_b !== 1'b1) begin
                errors++;
                $display("FAIL min_rdy: rdy=%b before code %0d, expected 1", rdy_b, k);
            end
            en_b = 1'b1;
            code_b = 3'(k);
            qb.push_back(onehot(3'(k)));
            cyc();
            e = qb.pop_front();
            checks++;
            if (y_b !== e || done_b !== 1'b1 || rdy_b !== 1'b0 || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL min_drive: y=%h done=%b rdy=%b busy=%b, expected %h 1 0 1",
                         y_b, done_b, rdy_b, busy_b, e);
            end
            cyc();
            checks++;
            if (y_b !== 8'h00 || done_b !== 1'b0 || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL min_zero: y=%h done=%b busy=%b, expected 00 0 0", y_b, done_b, busy_b);
            end
        end
        en_b = 1'b0;
    endtask

`ifdef DEC8_SWEEP_EN
    task automatic test_sweep();
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL sweep_rdy: rdy_out=%b before sweep, expected 1", rdy_out);
        end
        sweep_start = 1'b1;
        en_in = 1'b1;
        code_in = 3'd3;
        for (int k = 0; k < 8; k++) push_exp(onehot(3'(k)), 4, (k == 7) ? 1'b1 : 1'b0);
        cyc();
        sweep_start = 1'b0;
        en_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) cyc();
            checks++;
            if (busy !== 1'b1 || rdy_out !== 1'b0) begin
                errors++;
                $display("FAIL sweep_busy: cycle %0d busy=%b rdy=%b, expected 1 0", i, busy, rdy_out);
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end: busy=%b rdy=%b after 40 cycles, expected 0 1", busy, rdy_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_min_timing();
`ifdef DEC8_SWEEP_EN
        test_sweep();
`endif
        cyc();
        checks++;
        if (q.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d/%0d entries unmatched, expected 0/0", q.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
